// File: rtl/multi_data_sync.sv
// Multi-channel CDC capture: each channel synchronizes its enable, detects an edge,
// and latches that channel's source bus into a registered holding stage.
module multi_data_sync #(
  parameter int BUS_WIDTH  = 8,
  parameter int CH_NUM     = 4,
  parameter int NUM_STAGES = 2,
  parameter int EDGE_MODE  = 0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [CH_NUM*BUS_WIDTH-1:0] unsync_bus,
  input  logic [CH_NUM-1:0]           bus_enable,
  input  logic [CH_NUM-1:0]           sync_ready,
  input  logic [CH_NUM-1:0]           clr_overrun,
  output logic [CH_NUM*BUS_WIDTH-1:0] sync_bus,
  output logic [CH_NUM-1:0]           enable_pulse,
  output logic [CH_NUM-1:0]           sync_valid,
  output logic [CH_NUM-1:0]           ack,
  output logic [CH_NUM-1:0]           overrun
);

  // Handshake: sync_valid/sync_ready consume the held word on an edge where both are
  // high; a capture on that same edge replaces the word and keeps sync_valid high.
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [NUM_STAGES-1:0] sync_q, sync_d;
    logic                  hist_q;
    logic [BUS_WIDTH-1:0]  data_q, data_d;
    logic                  pulse_q;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;
    logic                  last;
    logic                  capture;

    assign last = sync_q[NUM_STAGES-1];

    always_comb begin
      sync_d  = {sync_q[NUM_STAGES-2:0], bus_enable[i]};
      capture = (EDGE_MODE != 0) ? (last ^ hist_q) : (last & ~hist_q);
      data_d  = capture ? unsync_bus[i*BUS_WIDTH +: BUS_WIDTH] : data_q;
      valid_d = capture | (valid_q & ~sync_ready[i]);
      // A fresh set wins over a same-edge clear.
      ovr_d   = (capture & valid_q & ~sync_ready[i]) | (ovr_q & ~clr_overrun[i]);
    end

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        sync_q  <= '0;
        hist_q  <= 1'b0;
        data_q  <= '0;
        pulse_q <= 1'b0;
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        hist_q  <= last;
        data_q  <= data_d;
        pulse_q <= capture;
        valid_q <= valid_d;
        ovr_q   <= ovr_d;
      end
    end

    assign sync_bus[i*BUS_WIDTH +: BUS_WIDTH] = data_q;
    assign enable_pulse[i] = pulse_q;
    assign sync_valid[i]   = valid_q;
    assign ack[i]          = last;
    assign overrun[i]      = ovr_q;
  end

endmodule

// File: tb/tb_multi_data_sync.sv
// Directed bench for multi_data_sync: default instance plus a toggle-mode, 3-stage instance.
module tb_multi_data_sync;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] ubus = '0;
  logic [3:0]  en = '0;
  logic [3:0]  en_t = '0;
  logic [3:0]  rdy = '0;
  logic [3:0]  clr = '0;

  logic [31:0] sbus, sbus_t;
  logic [3:0]  pulse, pulse_t, valid, valid_t, ackv, ack_t, ovr, ovr_t;

  int n_vec = 0;
  int n_miss = 0;

  always #5 CLK = ~CLK;

  multi_data_sync dut (
    .CLK(CLK), .RST(RST), .unsync_bus(ubus), .bus_enable(en), .sync_ready(rdy),
    .clr_overrun(clr), .sync_bus(sbus), .enable_pulse(pulse), .sync_valid(valid),
    .ack(ackv), .overrun(ovr)
  );

  multi_data_sync #(.EDGE_MODE(1), .NUM_STAGES(3)) dut_t (
    .CLK(CLK), .RST(RST), .unsync_bus(ubus), .bus_enable(en_t), .sync_ready(rdy),
    .clr_overrun(clr), .sync_bus(sbus_t), .enable_pulse(pulse_t), .sync_valid(valid_t),
    .ack(ack_t), .overrun(ovr_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d);
    ubus[ch*8 +: 8] = d;
  endtask

  logic [3:0] acc;

  initial begin
    // reset state
    #12;
    check("rst_bus", sbus, 32'h0);
    check("rst_flags", {pulse, valid, ackv, ovr}, 16'h0);
    step(1);
    RST = 1'b1;
    step(1);
    check("rel_no_pulse", {pulse, pulse_t, valid}, 12'h0);

    // ch0 basic capture, 2-stage latency
    set_ch(0, 8'hA5);
    en[0] = 1'b1;
    step(1);
    check("ch0_ack_e1", ackv[0], 1'b0);
    step(1);
    check("ch0_ack_e2", ackv[0], 1'b1);
    check("ch0_pulse_e2", pulse[0], 1'b0);
    step(1);
    check("ch0_pulse_e3", pulse, 4'b0001);
    check("ch0_data", sbus[7:0], 8'hA5);
    check("ch0_valid", valid, 4'b0001);
    step(1);
    check("ch0_pulse_1cyc", pulse[0], 1'b0);
    check("ch0_valid_hold", valid[0], 1'b1);
    rdy[0] = 1'b1;
    step(1);
    rdy[0] = 1'b0;
    check("ch0_consumed", valid[0], 1'b0);
    // falling edge in level mode: no pulse
    en[0] = 1'b0;
    acc = '0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      acc = acc | pulse;
    end
    check("ch0_fall_silent", acc, 4'b0000);

    // ch1 overrun
    set_ch(1, 8'h3C);
    en[1] = 1'b1;
    step(3);
    check("ch1_first", sbus[15:8], 8'h3C);
    en[1] = 1'b0;
    step(3);
    set_ch(1, 8'hC3);
    en[1] = 1'b1;
    step(3);
    check("ch1_overwrite", sbus[15:8], 8'hC3);
    check("ch1_overrun", ovr, 4'b0010);
    check("ch1_valid", valid[1], 1'b1);
    check("ch0_untouched", {valid[0], sbus[7:0]}, {1'b0, 8'hA5});
    clr[1] = 1'b1;
    step(1);
    clr[1] = 1'b0;
    check("ch1_clr", ovr[1], 1'b0);
    // set and clear on the same edge: stays set
    en[1] = 1'b0;
    step(3);
    set_ch(1, 8'h11);
    en[1] = 1'b1;
    step(2);
    clr[1] = 1'b1;
    step(1);
    clr[1] = 1'b0;
    check("ch1_set_wins", {ovr[1], sbus[15:8]}, {1'b1, 8'h11});
    clr[1] = 1'b1;
    rdy[1] = 1'b1;
    step(1);
    clr[1] = 1'b0;
    rdy[1] = 1'b0;
    check("ch1_cleanup", {ovr[1], valid[1]}, 2'b00);

    // ch2 consume coincident with capture
    rdy[2] = 1'b1;
    step(2);
    check("ch2_rdy_idle", {valid[2], ovr[2]}, 2'b00);
    rdy[2] = 1'b0;
    set_ch(2, 8'h55);
    en[2] = 1'b1;
    step(3);
    check("ch2_first", {valid[2], sbus[23:16]}, {1'b1, 8'h55});
    en[2] = 1'b0;
    step(3);
    set_ch(2, 8'h77);
    en[2] = 1'b1;
    step(2);
    rdy[2] = 1'b1;
    step(1);
    check("ch2_coincident", {valid[2], ovr[2], sbus[23:16]}, {1'b1, 1'b0, 8'h77});
    step(1);
    rdy[2] = 1'b0;
    check("ch2_consumed", valid[2], 1'b0);

    // toggle mode, 3 stages
    set_ch(0, 8'h5A);
    en_t[0] = 1'b1;
    step(3);
    check("tog_rise_e3", pulse_t[0], 1'b0);
    step(1);
    check("tog_rise_e4", {pulse_t[0], sbus_t[7:0]}, {1'b1, 8'h5A});
    step(1);
    check("tog_rise_1cyc", pulse_t[0], 1'b0);
    step(1);
    set_ch(0, 8'h96);
    en_t[0] = 1'b0;
    step(3);
    check("tog_fall_e3", pulse_t[0], 1'b0);
    step(1);
    check("tog_fall_e4", {pulse_t[0], sbus_t[7:0]}, {1'b1, 8'h96});
    check("tog_overrun", ovr_t[0], 1'b1);

    // reset with pending data on ch0..2, ch3 enable held high through release
    en[2:0] = 3'b000;
    step(3);
    set_ch(0, 8'h01);
    set_ch(1, 8'h02);
    set_ch(2, 8'h03);
    en[2:0] = 3'b111;
    step(3);
    check("pend_valid", valid, 4'b0111);
    set_ch(3, 8'hE7);
    en[3] = 1'b1;
    #2;
    RST = 1'b0;
    #1;
    check("arst_bus", sbus, 32'h0);
    check("arst_flags", {pulse, valid, ackv, ovr}, 16'h0);
    check("arst_tog", {sbus_t, pulse_t, valid_t, ack_t, ovr_t}, 48'h0);
    en[2:0] = 3'b000;
    step(2);
    RST = 1'b1;
    step(1);
    check("post_e1", {pulse, valid}, 8'h00);
    step(1);
    check("post_e2", {pulse, ackv}, 8'h08);
    step(1);
    check("post_e3", {pulse, valid}, 8'h88);
    check("post_data", sbus, 32'hE700_0000);
    step(1);
    check("post_1cyc", pulse, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/multi_data_sync.md
MULTI_DATA_SYNC -- requirements
Module: multi_data_sync

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8, data bits per channel.
REQ-002 The block SHALL have parameter CH_NUM, default 4, number of independent channels (1..16).
REQ-003 The block SHALL have parameter NUM_STAGES, default 2, synchronizer depth (legal 2..4).
REQ-004 The block SHALL have parameter EDGE_MODE, default 0, 0 = rising-edge detect of level enable, 1 = toggle detect (any edge).
REQ-005 CLK  input  1  destination-domain clock, all flops rising-edge; one clock only.
REQ-006 RST  input  1  asynchronous, active-low reset.
REQ-007 unsync_bus  input  CH_NUM*BUS_WIDTH  source-domain data, channel i at bits [i*BUS_WIDTH +: BUS_WIDTH].
REQ-008 bus_enable  input  CH_NUM  source-domain qualifier per channel, unsynchronized.
REQ-009 sync_ready  input  CH_NUM  downstream consume strobe per channel.
REQ-010 clr_overrun  input  CH_NUM  synchronous clear of overrun flag per channel.
REQ-011 sync_bus  output  CH_NUM*BUS_WIDTH  captured data, registered, same packing as unsync_bus.
REQ-012 enable_pulse  output  CH_NUM  one-cycle registered pulse per capture.
REQ-013 sync_valid  output  CH_NUM  captured data pending consumption.
REQ-014 ack  output  CH_NUM  last synchronizer stage of bus_enable, for source-side 4-phase/toggle handshake.
REQ-015 overrun  output  CH_NUM  sticky flag: capture overwrote unconsumed data.

Function
REQ-016 Each channel SHALL pass bus_enable[i] through a NUM_STAGES-deep flop chain; only unsync_bus bits SHALL bypass the chain and be sampled solely on capture.
REQ-017 A history flop SHALL hold the previous last-stage value; capture condition SHALL be (last & !hist) for EDGE_MODE=0, (last ^ hist) for EDGE_MODE=1.
REQ-018 On capture, sync_bus channel i SHALL load unsync_bus channel i at the next edge; otherwise it SHALL hold.
REQ-019 enable_pulse[i] SHALL be the registered capture condition, high exactly one cycle per detected edge, concurrent with new sync_bus.
REQ-020 Latency: bus_enable change set up before edge k SHALL produce enable_pulse and new sync_bus after edge k+NUM_STAGES (2 stages -> visible after 3rd edge).
REQ-021 ack[i] SHALL equal the last synchronizer stage (latency NUM_STAGES edges).
REQ-022 sync_valid[i] SHALL set on the edge loading sync_bus and clear on the edge where sync_valid & sync_ready with no simultaneous capture.
REQ-023 Simultaneous consume and capture: new data SHALL load, sync_valid SHALL stay 1, overrun SHALL NOT set.
REQ-024 Capture while sync_valid=1 and sync_ready=0: data SHALL be overwritten, sync_valid stays 1, overrun[i] SHALL set.
REQ-025 overrun[i] SHALL clear on clr_overrun[i]; simultaneous set and clear SHALL leave it set.
REQ-026 sync_ready while sync_valid=0 SHALL have no effect.
REQ-027 Channels SHALL be fully independent; no cross-channel coupling in any state.
REQ-028 EDGE_MODE=0: falling edge of bus_enable SHALL produce no pulse; EDGE_MODE=1: both edges SHALL capture.

Reset
REQ-029 On RST low, all synchronizer, history, sync_bus, enable_pulse, sync_valid, ack and overrun flops SHALL clear to 0 asynchronously.
REQ-030 Reset mid-operation SHALL drop pending data and flags; after release, a bus_enable already high SHALL be detected as a rising edge (EDGE_MODE=0) or toggle (EDGE_MODE=1) after NUM_STAGES+1 edges.
REQ-031 No output SHALL pulse during or on the first edge after reset release.

Verification
REQ-032 Defaults, ch0 unsync_bus=0xA5, bus_enable[0] 0->1 before edge 1 -> enable_pulse[0] high one cycle after edge 3, sync_bus[7:0]=0xA5, sync_valid[0]=1, ack[0]=1 after edge 2.
REQ-033 ch1 capture 0x3C, sync_ready=0, second enable edge with 0xC3 -> sync_bus ch1=0xC3, overrun[1]=1, sync_valid[1]=1; clr_overrun[1] one cycle -> overrun[1]=0.
REQ-034 sync_ready[2] asserted on same edge as new capture 0x77 -> sync_valid[2]=1, data 0x77, overrun[2]=0; next cycle sync_ready -> sync_valid[2]=0.
REQ-035 EDGE_MODE=1, NUM_STAGES=3, bus_enable[0] 0->1->0 with 6-cycle spacing -> two enable_pulse, each 4 edges after change.
REQ-036 RST low while sync_valid=3'b111 pending -> all outputs 0 immediately; release with bus_enable[3]=1 held -> single pulse on ch3 after 3 edges, others silent.
REQ-037 Random per-channel enables and ready over 10k cycles vs. reference model -> zero data/flag mismatches, no cross-channel effects.
